uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ byte-stream requesters, using packet-granular round-robin arbitration.
- Each requester presents bytes on a valid/ready handshake with a last flag.
- The arbiter locks the grant for a whole packet, then sequences uart_tx one byte at a time through its start/busy handshake.
- Sits between producer blocks (e.g. crypto/framing engines) and the uart_tx instance in the simplex TX top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ), minimum 1.
- BUSY_WAIT_MAX, 4, maximum cycles to wait for uart_busy to rise after uart_start before flagging an error.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  per-requester flag: the current byte ends its packet.
- req_ready  output  NUM_REQ  one-hot (or zero) byte-accept strobe.
- uart_start  output  1  one-cycle start pulse to uart_tx.
- uart_data  output  8  byte to uart_tx; registered, stable from the start pulse until uart_busy falls.
- uart_busy  input  1  busy from uart_tx.
- grant_id  output  ID_W  index of the current owner; valid while active=1.
- active  output  1  a packet is in progress.
- err_nobusy  output  1  sticky: uart_busy did not rise within BUSY_WAIT_MAX cycles of a start pulse.

Behaviour:
- Reset values: req_ready=0, uart_start=0, uart_data=0, grant_id=0, active=0, err_nobusy=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-packet aborts immediately. No partial-packet resume; the requester must resend.
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO (plus TAG when enabled).
- IDLE: if any req_valid is set, grant the first valid index scanning from rr_ptr upward with wrap. Register grant_id and set active=1, then go to LOAD next cycle. No valid: stay in IDLE.
- LOAD: if req_valid[grant_id]=1, drive req_ready[grant_id]=1 combinationally for that cycle. In the same edge, capture req_data into uart_data and req_last into last_q; go to START.
  - If valid is low, hold in LOAD with the grant locked; other requesters are ignored.
- START: uart_start=1 for exactly one cycle; go to WAIT_HI and clear the wait counter.
- WAIT_HI: wait for uart_busy=1, then go to WAIT_LO.
  - The counter increments each cycle. When it reaches BUSY_WAIT_MAX: set err_nobusy=1 and treat the byte as sent (proceed as on the busy fall).
- WAIT_LO: on uart_busy=0:
  - last_q=0: go to LOAD.
  - last_q=1: set active=0, rr_ptr=grant_id+1 (mod NUM_REQ), go to IDLE.
- Byte-to-byte gap: LOAD→START→WAIT_HI adds at most 3 cycles beyond uart_tx frame time.
- Fairness: after a packet from requester k, requester k has lowest priority in the next arbitration.
- A single-byte packet (last=1 on the first byte) is legal.
- req_ready is never asserted outside LOAD and never to a non-granted index.
- Changes to req_valid/req_data of non-granted requesters during a packet have no effect.
- err_nobusy clears only on rst.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined: after the grant in IDLE, go to TAG instead of LOAD.
  - TAG loads uart_data = {4'hA, 1'b0, grant_id zero-extended to 3 bits}, then runs START/WAIT_HI/WAIT_LO with last_q forced to 0, then LOAD.
  - Each packet on the line is therefore prefixed with one source-tag byte (requester 2 → 8'hA2).
- Undefined: no TAG state; packets go out untagged; the logic is absent.

Test Plan:
- Reset, then requester 0 sends 3 bytes 8'h11,8'h22,8'h33 with last on 8'h33; bench uart_tx model raises busy 1 cycle after start and holds it 10 cycles → three start pulses, uart_data sequence 11,22,33, three req_ready[0] pulses, active falls after the third busy fall, rr_ptr=1.
- Requesters 1 and 3 both valid with 2-byte packets, rr_ptr=0 → requester 1's packet fully sent, then requester 3's; no interleaving; grant_id 1 then 3.
- Requester 2 drops valid for 20 cycles mid-packet while requester 0 is valid → arbiter holds in LOAD with grant_id=2; requester 0 is served only after 2's last byte.
- All four requesters continuously valid with single-byte packets → grant order 0,1,2,3,0 with no starvation.
- Model never raises busy, BUSY_WAIT_MAX=4 → err_nobusy=1 four cycles after the start pulse; the arbiter continues with the next byte. Assert rst during WAIT_LO → all outputs return to reset values asynchronously.
- With UART_ARB_TAG_EN, requester 2 sends 8'h5C (last) → line bytes 8'hA2, 8'h5C; without the macro → 8'h5C only.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one uart_tx among NUM_REQ byte-stream requesters.
// Optional source-tag prefix byte per packet is enabled by defining UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_start,
  output logic [7:0]             uart_data,
  input  logic                   uart_busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   active,
  output logic                   err_nobusy
);

  localparam int CNT_W = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(BUSY_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
`ifdef UART_ARB_TAG_EN
    , ST_TAG   = 3'd5
`endif
  } state_t;

  state_t           state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic             last_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic [ID_W:0]    pick_s;
  logic [ID_W-1:0]  next_ptr_s;
  logic             cur_valid_s;
  logic             cur_last_s;
  logic [7:0]       cur_data_s;

  // First valid index at or above ptr with wrap; MSB of the result flags that one was found.
  // Scanning from the far end lets the closest candidate overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    logic [ID_W:0] sum;
    res = {(ID_W+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      sum = (sum >= (ID_W+1)'(NUM_REQ)) ? (sum - (ID_W+1)'(NUM_REQ)) : sum;
      res = valid[sum[ID_W-1:0]] ? {1'b1, sum[ID_W-1:0]} : res;
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req_valid, rr_ptr_r);
  assign cur_valid_s = req_valid[grant_id];
  assign cur_last_s  = req_last[grant_id];
  assign cur_data_s  = req_data[{grant_id, 3'b000} +: 8];

  // Pointer value that gives the current owner lowest priority next time.
  always_comb begin
    next_ptr_s = {ID_W{1'b0}};
    if (grant_id == LAST_ID) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_id + ID_W'(1);
    end
  end

  // Byte-accept strobe: only in LOAD, only to the owner, only while it offers a byte.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == ST_LOAD) && cur_valid_s) begin
      req_ready[grant_id] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration and byte-sequencing state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= {ID_W{1'b0}};
      last_r     <= 1'b0;
      wait_cnt_r <= {CNT_W{1'b0}};
      uart_start <= 1'b0;
      uart_data  <= 8'h00;
      grant_id   <= {ID_W{1'b0}};
      active     <= 1'b0;
      err_nobusy <= 1'b0;
    end else begin
      uart_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_s[ID_W]) begin
            grant_id <= pick_s[ID_W-1:0];
            active   <= 1'b1;
`ifdef UART_ARB_TAG_EN
            state_r  <= ST_TAG;
`else
            state_r  <= ST_LOAD;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG: begin
          uart_data  <= {4'hA, 1'b0, 3'(grant_id)};
          last_r     <= 1'b0;
          uart_start <= 1'b1;
          state_r    <= ST_START;
        end
`endif
        ST_LOAD: begin
          if (cur_valid_s) begin
            uart_data  <= cur_data_s;
            last_r     <= cur_last_s;
            uart_start <= 1'b1;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt_r <= {CNT_W{1'b0}};
          state_r    <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (uart_busy) begin
            state_r <= ST_WAIT_LO;
          end else if (wait_cnt_r == WAIT_LIMIT) begin
            // Transmitter never acknowledged: flag it and carry on as if the byte went out.
            err_nobusy <= 1'b1;
            if (last_r) begin
              active   <= 1'b0;
              rr_ptr_r <= next_ptr_s;
              state_r  <= ST_IDLE;
            end else begin
              state_r  <= ST_LOAD;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!uart_busy) begin
            if (last_r) begin
              active   <= 1'b0;
              rr_ptr_r <= next_ptr_s;
              state_r  <= ST_IDLE;
            end else begin
              state_r  <= ST_LOAD;
            end
          end
        end
        default: begin
          active  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model and line monitor.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic            uart_start;
  logic [7:0]      uart_data;
  logic            uart_busy = 1'b0;
  logic [1:0]      grant_id;
  logic            active;
  logic            err_nobusy;

  int n_checks = 0;
  int n_fail   = 0;
  bit dead     = 1'b0;
  int busy_left = 0;
  int epoch = 0;
  int seen_epoch = 0;
  logic [63:0] line_v = '0;
  logic [31:0] gid_v = '0;
  int line_n = 0;
  int ready_cnt [NR];
  int rdy_viol = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .BUSY_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy),
    .grant_id(grant_id), .active(active), .err_nobusy(err_nobusy)
  );

  // uart_tx model (busy for 10 cycles per start) plus line/handshake monitor
  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      line_v = '0; gid_v = '0; line_n = 0;
      for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
    end
    if (rst) begin
      busy_left = 0;
    end else begin
      if (uart_start) begin
        line_v = {line_v[55:0], uart_data};
        gid_v  = {gid_v[27:0], 2'b00, grant_id};
        line_n++;
        if (!dead) busy_left = 10;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      for (int i = 0; i < NR; i++) if (req_ready[i]) ready_cnt[i]++;
      if (req_ready != 4'b0000 && (!active || req_ready != (4'b0001 << grant_id))) rdy_viol++;
    end
    uart_busy = (busy_left > 0);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Bytes are packed first-byte-most-significant; gap = idle cycles between bytes.
  task automatic send_pkt(input int id, input int n, input logic [31:0] bytes, input int gap);
    int budget;
    for (int k = 0; k < n; k++) begin
      req_data[id*8 +: 8] = bytes[8*(n-1-k) +: 8];
      req_last[id]  = (k == n - 1);
      req_valid[id] = 1'b1;
      budget = 0;
      do begin @(negedge clk); budget++; end while (!req_ready[id] && budget < 400);
      n_checks++;
      if (!req_ready[id]) begin
        n_fail++;
        $display("FAIL send_timeout req%0d byte%0d: ready=%b, required 1", id, k, req_ready[id]);
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      if (k < n - 1) repeat (gap) @(posedge clk);
      if (k < n - 1 && gap > 0) #1;
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin @(negedge clk); budget++; end while ((active || uart_busy) && budget < 2000);
    n_checks++;
    if (active || uart_busy) begin
      n_fail++;
      $display("FAIL idle_timeout: active=%b busy=%b, required 0 0", active, uart_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready: got %h want 0", req_ready); end
    n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", uart_start); end
    n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", uart_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b want 0", active); end
    n_checks++; if (err_nobusy !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_nobusy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_req();
    epoch++;
    send_pkt(0, 3, 32'h112233, 0);
    wait_idle();
    n_checks++; if (line_v !== 64'h112233) begin n_fail++; $display("FAIL single_line: got %h want 112233", line_v); end
    n_checks++; if (line_n !== 3) begin n_fail++; $display("FAIL single_starts: got %0d want 3", line_n); end
    n_checks++; if (ready_cnt[0] !== 3) begin n_fail++; $display("FAIL single_ready: got %0d want 3", ready_cnt[0]); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL single_active: got %b want 0", active); end
    n_checks++; if (dut.rr_ptr_r !== 2'd1) begin n_fail++; $display("FAIL single_rrptr: got %0d want 1", dut.rr_ptr_r); end
  endtask

  task automatic test_two_req();
    do_reset();
    epoch++;
    fork
      send_pkt(1, 2, 32'h1A1B, 0);
      send_pkt(3, 2, 32'h3A3B, 0);
    join
    wait_idle();
    n_checks++; if (line_v !== 64'h1A1B3A3B) begin n_fail++; $display("FAIL two_line: got %h want 1a1b3a3b", line_v); end
    n_checks++; if (gid_v !== 32'h1133) begin n_fail++; $display("FAIL two_gid: got %h want 1133", gid_v); end
    n_checks++; if (ready_cnt[3] !== 2) begin n_fail++; $display("FAIL two_ready3: got %0d want 2", ready_cnt[3]); end
  endtask

  task automatic test_hold_load();
    epoch++;
    fork
      send_pkt(2, 2, 32'h2A2B, 20);
      begin
        int b = 0;
        do begin @(negedge clk); b++; end while (!active && b < 50);
        send_pkt(0, 1, 32'h0A, 0);
      end
      begin
        int b = 0;
        do begin @(negedge clk); b++; end while (!(line_n == 1 && !req_valid[2]) && b < 100);
        repeat (16) @(negedge clk);
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL hold_gid: got %0d want 2", grant_id); end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL hold_active: got %b want 1", active); end
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL hold_ready: got %h want 0", req_ready); end
      end
    join
    wait_idle();
    n_checks++; if (line_v !== 64'h2A2B0A) begin n_fail++; $display("FAIL hold_line: got %h want 2a2b0a", line_v); end
    n_checks++; if (gid_v !== 32'h220) begin n_fail++; $display("FAIL hold_gidseq: got %h want 220", gid_v); end
  endtask

  task automatic test_all_valid();
    do_reset();
    epoch++;
    fork
      begin send_pkt(0, 1, 32'hA0, 0); send_pkt(0, 1, 32'hA4, 0); end
      send_pkt(1, 1, 32'hB1, 0);
      send_pkt(2, 1, 32'hC2, 0);
      send_pkt(3, 1, 32'hD3, 0);
    join
    wait_idle();
    n_checks++; if (line_v !== 64'hA0B1C2D3A4) begin n_fail++; $display("FAIL rr_line: got %h want a0b1c2d3a4", line_v); end
    n_checks++; if (gid_v !== 32'h01230) begin n_fail++; $display("FAIL rr_gid: got %h want 01230", gid_v); end
  endtask

  task automatic test_nobusy();
    dead = 1'b1;
    epoch++;
    fork
      send_pkt(1, 2, 32'h4C4D, 0);
      begin
        int b = 0;
        do begin @(negedge clk); b++; end while (!uart_start && b < 50);
        @(negedge clk);
        n_checks++; if (err_nobusy !== 1'b0) begin n_fail++; $display("FAIL nobusy_early: got %b want 0", err_nobusy); end
        repeat (4) @(negedge clk);
        n_checks++; if (err_nobusy !== 1'b1) begin n_fail++; $display("FAIL nobusy_set: got %b want 1", err_nobusy); end
      end
    join
    wait_idle();
    n_checks++; if (line_v !== 64'h4C4D) begin n_fail++; $display("FAIL nobusy_line: got %h want 4c4d", line_v); end
    n_checks++; if (err_nobusy !== 1'b1) begin n_fail++; $display("FAIL nobusy_sticky: got %b want 1", err_nobusy); end
    dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b = 0;
    req_data[31:24] = 8'h77;
    req_last[3]  = 1'b0;
    req_valid[3] = 1'b1;
    do begin @(posedge clk); b++; end while (!uart_busy && b < 50);
    @(posedge clk);
    #3;
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL mid_pre_active: got %b want 1", active); end
    rst = 1'b1;
    #1;
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL mid_active: got %b want 0", active); end
    n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h want 00", uart_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_gid: got %0d want 0", grant_id); end
    n_checks++; if (err_nobusy !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b want 0", err_nobusy); end
    n_checks++; if (req_ready !== 4'h0 || uart_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_hs: ready=%h start=%b want 0 0", req_ready, uart_start);
    end
    req_valid[3] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_tag();
    do_reset();
    epoch++;
    send_pkt(2, 1, 32'h5C, 0);
    wait_idle();
`ifdef UART_ARB_TAG_EN
    n_checks++; if (line_v !== 64'hA25C) begin n_fail++; $display("FAIL tag_line: got %h want a25c", line_v); end
    n_checks++; if (gid_v !== 32'h22) begin n_fail++; $display("FAIL tag_gid: got %h want 22", gid_v); end
`else
    n_checks++; if (line_v !== 64'h5C) begin n_fail++; $display("FAIL tag_line: got %h want 5c", line_v); end
    n_checks++; if (gid_v !== 32'h2) begin n_fail++; $display("FAIL tag_gid: got %h want 2", gid_v); end
`endif
    n_checks++; if (ready_cnt[2] !== 1) begin n_fail++; $display("FAIL tag_ready: got %0d want 1", ready_cnt[2]); end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_two_req();
    test_hold_load();
    test_all_valid();
    test_nobusy();
    test_reset_mid();
    test_tag();
    n_checks++;
    if (rdy_viol !== 0) begin n_fail++; $display("FAIL ready_rule: %0d violations, want 0", rdy_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
